// File: rtl/alu_iter_pkg.sv
// -----------------------------------------------------------------------------
// alu_iter_pkg
// Shared definitions for the iterative ALU: opcode encodings, the control
// state type, and the helpers that derive the multiplier iteration count and
// check that RADIX divides WIDTH.
// -----------------------------------------------------------------------------
package alu_iter_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_MAC = 2'b11;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Number of shift-add iterations for one multiply.
   function automatic int calc_iters(input int width, input int radix);
      return width / radix;
   endfunction

   // True when radix is a legal divisor of width.
   function automatic bit radix_ok(input int width, input int radix);
      return (radix > 0) && (radix <= width) && ((width % radix) == 0);
   endfunction

endpackage

// File: rtl/alu_iter_if.sv
// -----------------------------------------------------------------------------
// alu_iter_if
// Operand/result bus of the iterative ALU.
//   in_valid / in_ready : operand handshake (transfer when both high on posedge)
//   A, B                : signed operands, WIDTH bits
//   opCode              : 00 ADD, 01 SUB, 10 MUL, 11 MAC
//   acc_clr             : MAC only, treat accumulator as zero for this op
//   C                   : signed 2*WIDTH result, holds until next completion
//   completed           : one-cycle pulse, C updated at the same edge
// master = operand issuer / result consumer, slave = the ALU.
// -----------------------------------------------------------------------------
interface alu_iter_if #(
   parameter int WIDTH = 64
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      A;
   logic [WIDTH-1:0]      B;
   logic [1:0]            opCode;
   logic                  acc_clr;
   logic [2*WIDTH-1:0]    C;
   logic                  completed;

   modport master (
      output in_valid, A, B, opCode, acc_clr,
      input  in_ready, C, completed
   );

   modport slave (
      input  in_valid, A, B, opCode, acc_clr,
      output in_ready, C, completed
   );
endinterface

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Unsigned iterative shift-add multiplier, RADIX multiplier bits per cycle.
//   clk, resetn : clock, asynchronous active-low reset
//   i_start     : load magnitudes; iterations follow on the next N edges
//   i_mag_a/b   : WIDTH-bit unsigned multiplicand / multiplier
//   o_done      : high during the cycle whose closing edge is the last
//                 iteration; o_product then already includes that iteration
//   o_product   : 2*WIDTH product after the current cycle's iteration
// -----------------------------------------------------------------------------
module alu_mul_iter
   import alu_iter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int RADIX = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_mag_a,
   input  logic [WIDTH-1:0]     i_mag_b,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_product
);
   localparam int N  = calc_iters(WIDTH, RADIX);
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_prod;
   logic [CW-1:0]      r_cnt;
   logic               r_active;
   logic [2*WIDTH-1:0] w_prod_next;

   // Partial-product accumulation for the RADIX low multiplier bits.
   always_comb begin
      w_prod_next = r_prod;
      for (int k = 0; k < RADIX; k++) begin
         if (r_mplier[k]) begin
            w_prod_next = w_prod_next + (r_mcand << k);
         end else begin
            w_prod_next = w_prod_next;
         end
      end
   end

   // Operand load and per-cycle shift-add iteration.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= {{WIDTH{1'b0}}, i_mag_a};
         r_mplier <= i_mag_b;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_active <= 1'b1;
      end else if (r_active) begin
         r_prod   <= w_prod_next;
         r_mcand  <= r_mcand << RADIX;
         r_mplier <= r_mplier >> RADIX;
         r_cnt    <= r_cnt + CW'(1);
         if (r_cnt == LAST) begin
            r_active <= 1'b0;
         end else begin
            r_active <= 1'b1;
         end
      end else begin
         r_active <= 1'b0;
      end
   end

   assign o_done    = r_active && (r_cnt == LAST);
   assign o_product = w_prod_next;

endmodule

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
// Handshaked signed ALU: ADD/SUB in one cycle, MUL/MAC via an iterative
// shift-add core (N = WIDTH/RADIX cycles). Results are 2*WIDTH wide.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : alu_iter_if slave (operands, handshake, C, completed)
// -----------------------------------------------------------------------------
module alu_iter
   import alu_iter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int RADIX = 1
) (
   input  logic        clk,
   input  logic        resetn,
   alu_iter_if.slave   bus
);
   if (!radix_ok(WIDTH, RADIX)) begin : g_bad_radix
      $error("alu_iter: RADIX must divide WIDTH");
   end

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

   state_t               r_state;
   logic                 r_in_ready;
   logic [2*WIDTH-1:0]   r_c;
   logic                 r_completed;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_sign;
   logic                 r_is_mac;
   logic                 r_acc_clr;

   logic                 w_xfer;
   logic                 w_start;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_ext_a;
   logic [2*WIDTH-1:0]   w_ext_b;
   logic                 w_mul_done;
   logic [2*WIDTH-1:0]   w_product;
   logic [2*WIDTH-1:0]   w_signed_prod;
   logic [2*WIDTH-1:0]   w_mac_sum;
   logic [2*WIDTH-1:0]   w_result;

   assign w_xfer  = bus.in_valid && (r_state == IDLE);
   assign w_start = w_xfer && bus.opCode[1];

   // Two's-complement negation of the most negative value yields 2^(WIDTH-1),
   // which is the correct magnitude when read as unsigned.
   assign w_mag_a = bus.A[WIDTH-1] ? (~bus.A + ONE_W) : bus.A;
   assign w_mag_b = bus.B[WIDTH-1] ? (~bus.B + ONE_W) : bus.B;

   assign w_ext_a = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
   assign w_ext_b = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};

   alu_mul_iter #(
      .WIDTH (WIDTH),
      .RADIX (RADIX)
   ) u_mul (
      .clk       (clk),
      .resetn    (resetn),
      .i_start   (w_start),
      .i_mag_a   (w_mag_a),
      .i_mag_b   (w_mag_b),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // Sign fix-up and accumulate happen on the same edge as the final iteration.
   assign w_signed_prod = r_sign ? (~w_product + {{WIDTH{1'b0}}, ONE_W}) : w_product;
   assign w_mac_sum     = (r_acc_clr ? {(2*WIDTH){1'b0}} : r_acc) + w_signed_prod;
   assign w_result      = r_is_mac ? w_mac_sum : w_signed_prod;

   // Control FSM with registered result, pulse, ready and accumulator.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_c         <= '0;
         r_completed <= 1'b0;
         r_acc       <= '0;
         r_sign      <= 1'b0;
         r_is_mac    <= 1'b0;
         r_acc_clr   <= 1'b0;
      end else begin
         r_completed <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  case (bus.opCode)
                     OP_ADD: begin
                        r_c         <= w_ext_a + w_ext_b;
                        r_completed <= 1'b1;
                     end
                     OP_SUB: begin
                        r_c         <= w_ext_a - w_ext_b;
                        r_completed <= 1'b1;
                     end
                     OP_MUL, OP_MAC: begin
                        r_sign     <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        r_is_mac   <= (bus.opCode == OP_MAC);
                        r_acc_clr  <= bus.acc_clr;
                        r_state    <= BUSY;
                        r_in_ready <= 1'b0;
                     end
                     default: begin
                        r_state <= IDLE;
                     end
                  endcase
               end else begin
                  r_state <= IDLE;
               end
            end
            BUSY: begin
               if (w_mul_done) begin
                  r_c         <= w_result;
                  r_completed <= 1'b1;
                  r_state     <= IDLE;
                  r_in_ready  <= 1'b1;
                  if (r_is_mac) begin
                     r_acc <= w_mac_sum;
                  end else begin
                     r_acc <= r_acc;
                  end
               end else begin
                  r_state <= BUSY;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.C         = r_c;
   assign bus.completed = r_completed;

endmodule
